// File: rtl/l15_resp_model.sv
// L1.5 responder stand-in: accepts one LOAD/STORE/IFILL at a time and returns
// its response after a fixed latency. Backed by a word memory and can inject invalidations.
//
// state | meaning
// IDLE  | ready: takes an invalidation (priority) or acks a request
// WAIT  | latency countdown; memory operation happens on the last WAIT cycle
// RESP  | return held valid and stable until rtrn_ack_i
module l15_resp_model #(
    parameter int          MemWords    = 1024,
    parameter int          RespLatency = 4,
    parameter logic [63:0] OobData     = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_val_i,
    output logic         req_ack_o,
    input  logic [1:0]   req_type_i,
    input  logic [39:0]  req_addr_i,
    input  logic [1:0]   req_size_i,
    input  logic [63:0]  req_data_i,
    input  logic         inval_val_i,
    input  logic [39:0]  inval_addr_i,
    output logic         rtrn_val_o,
    input  logic         rtrn_ack_i,
    output logic [1:0]   rtrn_type_o,
    output logic [255:0] rtrn_data_o,
    output logic [39:0]  rtrn_addr_o
);
    localparam int IdxW = $clog2(MemWords);

    localparam logic [1:0] REQ_LOAD  = 2'd0;
    localparam logic [1:0] REQ_STORE = 2'd1;
    localparam logic [1:0] REQ_IFILL = 2'd2;

    localparam logic [1:0] RET_LOAD  = 2'd0;
    localparam logic [1:0] RET_ST    = 2'd1;
    localparam logic [1:0] RET_IFILL = 2'd2;
    localparam logic [1:0] RET_INV   = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, next_state;

    logic [63:0]  mem [MemWords];

    logic [1:0]   cur_type;
    logic [39:0]  cur_addr;
    logic [1:0]   cur_size;
    logic [63:0]  cur_data;
    logic [7:0]   cnt;

    logic         ret_val;
    logic [1:0]   ret_type;
    logic [255:0] ret_data;
    logic [39:0]  ret_addr;

    logic         req_ack;
    logic         do_op;

    logic [1:0]   op_type;
    logic [39:0]  op_addr;
    logic [1:0]   op_size;
    logic [63:0]  op_data;

    logic [IdxW-1:0] word_idx;
    logic            word_in_range;
    logic [36:0]     line_base;
    logic [36:0]     fill_idx [4];
    logic [63:0]     fill_word [4];
    logic [63:0]     load_word;
    logic [7:0]      lane_bits;
    logic [7:0]      byte_mask;
    logic [1:0]      resp_type;
    logic [255:0]    resp_data;
    logic            wr_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ack    = 1'b0;
        do_op      = 1'b0;
        case (state)
            IDLE: begin
                if (inval_val_i) begin
                    next_state = RESP;
                end else if (req_val_i) begin
                    req_ack = 1'b1;
                    if (RespLatency == 1) begin
                        do_op      = 1'b1;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 8'd1) begin
                    do_op      = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rtrn_ack_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With a latency of 1 the operation happens in the accept cycle, so take the live request.
    assign op_type = (state == IDLE) ? req_type_i : cur_type;
    assign op_addr = (state == IDLE) ? req_addr_i : cur_addr;
    assign op_size = (state == IDLE) ? req_size_i : cur_size;
    assign op_data = (state == IDLE) ? req_data_i : cur_data;

    assign word_idx      = op_addr[3 +: IdxW];
    assign word_in_range = op_addr[39:3] < 37'(MemWords);
    assign line_base     = {op_addr[39:5], 2'b00};
    assign load_word     = word_in_range ? mem[word_idx] : OobData;

    // Lanes beyond byte 7 fall off the top of the shift rather than wrapping.
    assign lane_bits = 8'hFF >> (4'd8 - (4'd1 << op_size));
    assign byte_mask = lane_bits << op_addr[2:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fill_idx[k]  = line_base + 37'(k);
            fill_word[k] = (fill_idx[k] < 37'(MemWords)) ? mem[fill_idx[k][IdxW-1:0]] : OobData;
        end
    end

    always_comb begin
        resp_type = RET_LOAD;
        resp_data = '0;
        case (op_type)
            REQ_LOAD:  resp_data = {192'd0, load_word};
            REQ_STORE: resp_type = RET_ST;
            REQ_IFILL: begin
                resp_type = RET_IFILL;
                resp_data = {fill_word[3], fill_word[2], fill_word[1], fill_word[0]};
            end
            default:   resp_data = '0;
        endcase
    end

    assign wr_en = do_op && !rst_i && (op_type == REQ_STORE) && word_in_range;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_mask[i]) mem[word_idx][8*i +: 8] <= op_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_type <= '0;
            cur_addr <= '0;
            cur_size <= '0;
            cur_data <= '0;
            cnt      <= '0;
            ret_val  <= 1'b0;
            ret_type <= '0;
            ret_data <= '0;
            ret_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inval_val_i) begin
                        ret_val  <= 1'b1;
                        ret_type <= RET_INV;
                        ret_data <= '0;
                        ret_addr <= inval_addr_i;
                    end else if (req_ack) begin
                        cur_type <= req_type_i;
                        cur_addr <= req_addr_i;
                        cur_size <= req_size_i;
                        cur_data <= req_data_i;
                        cnt      <= 8'(RespLatency - 1);
                    end
                end
                WAIT:    cnt <= cnt - 8'd1;
                RESP:    if (rtrn_ack_i) ret_val <= 1'b0;
                default: ;
            endcase
            if (do_op) begin
                ret_val  <= 1'b1;
                ret_type <= resp_type;
                ret_data <= resp_data;
                ret_addr <= op_addr;
            end
        end
    end

    assign req_ack_o   = req_ack;
    assign rtrn_val_o  = ret_val;
    assign rtrn_type_o = ret_type;
    assign rtrn_data_o = ret_data;
    assign rtrn_addr_o = ret_addr;
endmodule
